// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundle between the two data-memory requesters, the arbiter
// and the single-ported data memory.
//   pN_req/we/addr/wdata/funct3 : request fields from port N (0 = CPU, 1 = debug/DMA)
//   pN_gnt/rvalid/rdata         : grant, load-data valid pulse and load data back to port N
//   p1_starved                  : port 1 has waited the maximum number of cycles
//   MemRead/MemWrite/a/wd/Funct3: access presented to the data memory
//   rd                          : data memory read data (combinational from a/Funct3)
// Modports: slave = arbiter side, master = requesters + memory side.
interface dm_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [DM_ADDRESS-1:0] p0_addr;
  logic [DATA_W-1:0]     p0_wdata, p0_rdata;
  logic [2:0]            p0_funct3;
  logic                  p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [DM_ADDRESS-1:0] p1_addr;
  logic [DATA_W-1:0]     p1_wdata, p1_rdata;
  logic [2:0]            p1_funct3;
  logic                  p1_starved;
  logic                  MemRead, MemWrite;
  logic [DM_ADDRESS-1:0] a;
  logic [DATA_W-1:0]     wd, rd;
  logic [2:0]            Funct3;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
    input  rd,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_starved,
    output MemRead, MemWrite, a, wd, Funct3
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_funct3,
    output rd,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_starved,
    input  MemRead, MemWrite, a, wd, Funct3
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-ported data memory between the CPU load/store
// path (port 0) and a secondary master (port 1). One access per cycle, granted
// combinationally; load data is registered back to the winner one cycle later.
// Port 1 starvation is bounded by a saturating wait counter.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : dm_arbiter_if.slave (requests, grants, load data, memory side)
module dm_arbiter #(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int CPU_PRIORITY = 1,
  parameter int MAX_WAIT     = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  dm_arbiter_if.slave   bus
);
  localparam int NP = 2;

  logic [NP-1:0]                 w_req, w_we, w_gnt;
  logic [NP-1:0][DM_ADDRESS-1:0] w_addr;
  logic [NP-1:0][DATA_W-1:0]     w_wdata;
  logic [NP-1:0][2:0]            w_f3;
  logic                          w_any, w_win, w_starved;
  logic                          w_mrd, w_mwr;
  logic [DM_ADDRESS-1:0]         w_a;
  logic [DATA_W-1:0]             w_wd;
  logic [2:0]                    w_fn;

  logic [NP-1:0]                 r_rvalid;
  logic [NP-1:0][DATA_W-1:0]     r_rdata;
  logic                          r_last;   // port granted most recently
  logic [7:0]                    r_wait;

  assign w_req   = {bus.p1_req,    bus.p0_req};
  assign w_we    = {bus.p1_we,     bus.p0_we};
  assign w_addr  = {bus.p1_addr,   bus.p0_addr};
  assign w_wdata = {bus.p1_wdata,  bus.p0_wdata};
  assign w_f3    = {bus.p1_funct3, bus.p0_funct3};

  // Gated by reset_n so the flag reads 0 while reset is held.
  assign w_starved = reset_n && (r_wait == 8'(MAX_WAIT));

  always_comb begin
    w_gnt = '0;
    if (reset_n) begin
      if (&w_req) begin
        if (w_starved)             w_gnt = 2'b10;
        else if (CPU_PRIORITY != 0) w_gnt = 2'b01;
        else                       w_gnt = r_last ? 2'b01 : 2'b10;
      end else begin
        w_gnt = w_req;
      end
    end
  end

  assign w_any = |w_gnt;
  assign w_win = w_gnt[1];

  always_comb begin
    w_mrd = 1'b0;
    w_mwr = 1'b0;
    w_a   = '0;
    w_wd  = '0;
    w_fn  = '0;
    if (w_any) begin
      w_mrd = ~w_we[w_win];
      w_mwr =  w_we[w_win];
      w_a   = w_addr[w_win];
      w_wd  = w_wdata[w_win];
      w_fn  = w_f3[w_win];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last <= 1'b1;   // port 0 wins the first round-robin tie
      r_wait <= '0;
    end else begin
      if (w_any) r_last <= w_win;
      if (w_gnt[1] || !w_req[1])        r_wait <= '0;
      else if (r_wait != 8'(MAX_WAIT))  r_wait <= r_wait + 8'd1;
    end
  end

  // Load return path: rd sampled at the end of the grant cycle.
  for (genvar p = 0; p < NP; p++) begin : g_port
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_rvalid[p] <= 1'b0;
        r_rdata[p]  <= '0;
      end else begin
        r_rvalid[p] <= w_gnt[p] & ~w_we[p];
        if (w_gnt[p] && !w_we[p]) r_rdata[p] <= bus.rd;
      end
    end
  end

  assign bus.p0_gnt     = w_gnt[0];
  assign bus.p1_gnt     = w_gnt[1];
  assign bus.p0_rvalid  = r_rvalid[0];
  assign bus.p1_rvalid  = r_rvalid[1];
  assign bus.p0_rdata   = r_rdata[0];
  assign bus.p1_rdata   = r_rdata[1];
  assign bus.p1_starved = w_starved;
  assign bus.MemRead    = w_mrd;
  assign bus.MemWrite   = w_mwr;
  assign bus.a          = w_a;
  assign bus.wd         = w_wd;
  assign bus.Funct3     = w_fn;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: instance 0 uses CPU priority, instance 1 round-robin.
// A behavioural memory stands in for datamemory on each instance.
module tb_dm_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n;
  logic [1:0][1:0]           req, we, gnt, rvalid;
  logic [1:0][1:0][AW-1:0]   addr;
  logic [1:0][1:0][DW-1:0]   wdata, rdata;
  logic [1:0][1:0][2:0]      f3;
  logic [1:0]                mrd, mwr, starved;
  logic [1:0][AW-1:0]        ma;
  logic [1:0][DW-1:0]        mwd, mrdv;
  logic [1:0][2:0]           mf3;
  logic [DW-1:0]             mem [2][128];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dm_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) bus ();
    assign bus.p0_req    = req[k][0];
    assign bus.p0_we     = we[k][0];
    assign bus.p0_addr   = addr[k][0];
    assign bus.p0_wdata  = wdata[k][0];
    assign bus.p0_funct3 = f3[k][0];
    assign bus.p1_req    = req[k][1];
    assign bus.p1_we     = we[k][1];
    assign bus.p1_addr   = addr[k][1];
    assign bus.p1_wdata  = wdata[k][1];
    assign bus.p1_funct3 = f3[k][1];
    assign bus.rd        = mrdv[k];
    assign gnt[k]        = {bus.p1_gnt, bus.p0_gnt};
    assign rvalid[k]     = {bus.p1_rvalid, bus.p0_rvalid};
    assign rdata[k]      = {bus.p1_rdata, bus.p0_rdata};
    assign starved[k]    = bus.p1_starved;
    assign mrd[k]        = bus.MemRead;
    assign mwr[k]        = bus.MemWrite;
    assign ma[k]         = bus.a;
    assign mwd[k]        = bus.wd;
    assign mf3[k]        = bus.Funct3;
    assign mrdv[k]       = mem[k][ma[k][8:2]];
    dm_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .CPU_PRIORITY(k == 0 ? 1 : 0),
                 .MAX_WAIT(MW)) u_dut (.clk(clk), .reset_n(rst_n), .bus(bus));
  end

  // Memory: preload, then write on the falling edge.
  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 128; i++) mem[k][i] = (i * 32'h0001_0001) ^ 32'hA5A5_0000;
    mem[0][4] = 32'hDEAD_BEEF;
    mem[1][4] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (mwr[k]) mem[k][ma[k][8:2]] <= mwd[k];
    end
  end

  // ---------------- reference model ----------------
  int           checks = 0, errors = 0;
  int           m_last [2], m_wait [2], m_w [2];
  logic [1:0]   m_rv [2];
  logic [DW-1:0] m_rd [2][2];
  logic [DW-1:0] ref_mem [2][128];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Who should own the memory this cycle (-1 = nobody).
  function automatic int winner(int k);
    if (!rst_n || req[k] == 2'b00) return -1;
    if (req[k] == 2'b01) return 0;
    if (req[k] == 2'b10) return 1;
    if (m_wait[k] >= MW) return 1;
    if (k == 0) return 0;
    return 1 - m_last[k];
  endfunction

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      int w;
      logic e_rd, e_wr;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_wd;
      logic [2:0] e_f;
      w = winner(k);
      e_rd = 1'b0; e_wr = 1'b0; e_a = '0; e_wd = '0; e_f = '0;
      if (w >= 0) begin
        e_rd = !we[k][w]; e_wr = we[k][w]; e_a = addr[k][w];
        e_wd = wdata[k][w]; e_f = f3[k][w];
      end
      chk($sformatf("k%0d gnt", k), 32'(gnt[k]), 32'({w == 1, w == 0}));
      chk($sformatf("k%0d MemRead/MemWrite", k), 32'({mrd[k], mwr[k]}), 32'({e_rd, e_wr}));
      chk($sformatf("k%0d a", k), 32'(ma[k]), 32'(e_a));
      chk($sformatf("k%0d wd", k), mwd[k], e_wd);
      chk($sformatf("k%0d Funct3", k), 32'(mf3[k]), 32'(e_f));
      chk($sformatf("k%0d starved", k), 32'(starved[k]), 32'(rst_n && m_wait[k] == MW));
      chk($sformatf("k%0d rvalid", k), 32'(rvalid[k]), 32'(m_rv[k]));
      chk($sformatf("k%0d rdata0", k), rdata[k][0], m_rd[k][0]);
      chk($sformatf("k%0d rdata1", k), rdata[k][1], m_rd[k][1]);
    end
  endtask

  // Advance the model across the coming rising edge using current inputs.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int w;
      w = winner(k);
      m_w[k] = w;
      if (!rst_n) begin
        m_last[k] = 1; m_wait[k] = 0; m_rv[k] = 2'b00;
        m_rd[k][0] = '0; m_rd[k][1] = '0;
      end else begin
        m_rv[k] = 2'b00;
        if (w >= 0) begin
          m_last[k] = w;
          if (we[k][w]) ref_mem[k][addr[k][w][8:2]] = wdata[k][w];
          else begin
            m_rv[k][w] = 1'b1;
            m_rd[k][w] = ref_mem[k][addr[k][w][8:2]];
          end
        end
        if (w == 1 || !req[k][1]) m_wait[k] = 0;
        else if (m_wait[k] < MW) m_wait[k]++;
      end
    end
  endtask

  task automatic adv();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    #2;
    check_model();
    adv();
  endtask

  // ---------------- directed table (instance 0, CPU priority) ----------------
  typedef struct {
    logic rst; logic [1:0] req, we; logic [8:0] a0, a1; logic [31:0] wd0; logic [2:0] f;
    logic [1:0] e_gnt; logic e_rd, e_wr; logic [8:0] e_a; logic [1:0] e_rv;
    logic [31:0] e_d0, e_d1;
  } vec_t;
  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b0, 2'b11, 2'b00, 9'h010, 9'h020, 32'h0, 3'd2, 2'b00, 1'b0, 1'b0, 9'h000, 2'b00, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 2'b01, 2'b00, 9'h010, 9'h020, 32'h0, 3'd2, 2'b01, 1'b1, 1'b0, 9'h010, 2'b00, 32'h0, 32'h0};
    tbl[2] = '{1'b1, 2'b00, 2'b00, 9'h010, 9'h020, 32'h0, 3'd2, 2'b00, 1'b0, 1'b0, 9'h000, 2'b01, 32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b1, 2'b01, 2'b01, 9'h020, 9'h020, 32'h12345678, 3'd2, 2'b01, 1'b0, 1'b1, 9'h020, 2'b00, 32'hDEADBEEF, 32'h0};
    tbl[4] = '{1'b1, 2'b10, 2'b00, 9'h020, 9'h020, 32'h0, 3'd2, 2'b10, 1'b1, 1'b0, 9'h020, 2'b00, 32'hDEADBEEF, 32'h0};
    tbl[5] = '{1'b1, 2'b00, 2'b00, 9'h020, 9'h020, 32'h0, 3'd2, 2'b00, 1'b0, 1'b0, 9'h000, 2'b10, 32'hDEADBEEF, 32'h12345678};
    tbl[6] = '{1'b1, 2'b01, 2'b00, 9'h010, 9'h020, 32'h0, 3'd2, 2'b01, 1'b1, 1'b0, 9'h010, 2'b00, 32'hDEADBEEF, 32'h12345678};
    tbl[7] = '{1'b1, 2'b01, 2'b00, 9'h020, 9'h020, 32'h0, 3'd2, 2'b01, 1'b1, 1'b0, 9'h020, 2'b01, 32'hDEADBEEF, 32'h12345678};
    tbl[8] = '{1'b1, 2'b00, 2'b00, 9'h020, 9'h020, 32'h0, 3'd2, 2'b00, 1'b0, 1'b0, 9'h000, 2'b01, 32'h12345678, 32'h12345678};

    for (int k = 0; k < 2; k++) begin
      m_w[k] = -1;
      for (int i = 0; i < 128; i++) ref_mem[k][i] = (i * 32'h0001_0001) ^ 32'hA5A5_0000;
      ref_mem[k][4] = 32'hDEAD_BEEF;
    end
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; f3 = '0;
    adv();

    for (int i = 0; i < 9; i++) begin
      rst_n = tbl[i].rst; req[0] = tbl[i].req; we[0] = tbl[i].we;
      addr[0][0] = tbl[i].a0; addr[0][1] = tbl[i].a1; wdata[0][0] = tbl[i].wd0;
      f3[0][0] = tbl[i].f; f3[0][1] = tbl[i].f;
      #2;
      chk($sformatf("tbl%0d gnt", i), 32'(gnt[0]), 32'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d rd/wr", i), 32'({mrd[0], mwr[0]}), 32'({tbl[i].e_rd, tbl[i].e_wr}));
      chk($sformatf("tbl%0d a", i), 32'(ma[0]), 32'(tbl[i].e_a));
      chk($sformatf("tbl%0d rvalid", i), 32'(rvalid[0]), 32'(tbl[i].e_rv));
      chk($sformatf("tbl%0d rdata0", i), rdata[0][0], tbl[i].e_d0);
      chk($sformatf("tbl%0d rdata1", i), rdata[0][1], tbl[i].e_d1);
      check_model();
      adv();
    end

    // Idle: nothing moves for 20 cycles.
    req = '0; we = '0;
    for (int i = 0; i < 20; i++) begin
      #2;
      chk("idle", 32'({gnt[0], rvalid[0], mrd[0], mwr[0], ma[0]}), 32'h0);
      check_model();
      adv();
    end

    // Starvation with CPU priority: p1 wins every 9th cycle.
    req[0] = 2'b11; we[0] = 2'b00; addr[0][0] = 9'h010; addr[0][1] = 9'h020;
    for (int i = 0; i < 27; i++) begin
      #2;
      chk("starve gnt", 32'(gnt[0]), (i % 9 == 8) ? 32'd2 : 32'd1);
      chk("starve flag", 32'(starved[0]), 32'(i % 9 == 8));
      check_model();
      adv();
    end
    req[0] = 2'b00;
    step();

    // Round-robin: p0 (store) and p1 (load) alternate starting with p0.
    req[1] = 2'b11; we[1] = 2'b01; addr[1][0] = 9'h040; wdata[1][0] = 32'h55AA_33CC;
    addr[1][1] = 9'h010;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("rr gnt", 32'(gnt[1]), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr rd/wr", 32'({mrd[1], mwr[1]}), (i % 2 == 0) ? 32'd1 : 32'd2);
      check_model();
      adv();
    end
    req[1] = 2'b00;
    step();

    // Load granted, reset edge at the end of that cycle: no rvalid.
    req[0] = 2'b01; we[0] = 2'b00; addr[0][0] = 9'h010;
    #2;
    chk("mid-reset gnt", 32'(gnt[0]), 32'd1);
    check_model();
    #1 rst_n = 1'b0;
    adv();
    rst_n = 1'b1; req[0] = 2'b00;
    #2;
    chk("mid-reset rvalid", 32'(rvalid[0]), 32'd0);
    chk("mid-reset rdata0", rdata[0][0], 32'h0);
    check_model();
    adv();
    req[0] = 2'b01;
    #2;
    chk("re-present gnt", 32'(gnt[0]), 32'd1);
    check_model();
    adv();
    req[0] = 2'b00;
    #2;
    chk("re-present rvalid", 32'(rvalid[0]), 32'd1);
    chk("re-present rdata0", rdata[0][0], 32'hDEAD_BEEF);
    check_model();
    adv();

    // Random traffic; ungranted requests hold their fields.
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++)
          if (!(req[k][p] && m_w[k] != p)) begin
            req[k][p]   = ($urandom_range(0, 9) < ((p == 0) ? 9 : 6));
            we[k][p]    = ($urandom_range(0, 2) == 0);
            addr[k][p]  = 9'($urandom_range(0, 15) * 4);
            wdata[k][p] = $urandom;
            f3[k][p]    = 3'($urandom_range(0, 7));
          end
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single-ported data memory between the CPU load/store path (port 0) and a secondary master such as debug or DMA (port 1). It sits directly in front of `datamemory` and drives its MemRead/MemWrite/a/wd/Funct3 inputs. It grants at most one access per cycle and registers read data back to the winning requester. Starvation of port 1 is bounded by a wait counter.

## Interface
- DM_ADDRESS, 9: address width, equal to the data memory address width
- DATA_W, 32: data width
- CPU_PRIORITY, 1: 1 = port 0 has fixed priority, subject to the starvation override; 0 = round-robin
- MAX_WAIT, 8: cycles port 1 may wait before it is forced to win; range 1..255
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- pN_req  in  1  port N (N = 0,1) access request; held with its fields stable until pN_gnt
- pN_we  in  1  1 = store, 0 = load
- pN_addr  in  DM_ADDRESS  byte address
- pN_wdata  in  DATA_W  store data
- pN_funct3  in  3  RISC-V width code, passed through unchanged
- pN_gnt  out  1  access presented to memory this cycle
- pN_rvalid  out  1  one-cycle pulse: pN_rdata holds load result
- pN_rdata  out  DATA_W  registered load data
- p1_starved  out  1  wait counter has reached MAX_WAIT
- MemRead, MemWrite  out  1  to data memory
- a  out  DM_ADDRESS  to data memory
- wd  out  DATA_W  to data memory
- Funct3  out  3  to data memory
- rd  in  DATA_W  data memory read data, combinational from a/Funct3

## Operation
- Winner select (combinational) each cycle from p0_req, p1_req, last_gnt, wait_cnt:
  - only one port requesting: that port wins.
  - both requesting, p1_starved=1: port 1 wins.
  - both requesting, CPU_PRIORITY=1: port 0 wins.
  - both requesting, CPU_PRIORITY=0: the port other than last_gnt wins.
- Winner's pN_gnt=1. MemRead=~we, MemWrite=we. a/wd/Funct3 come from the winner's fields.
- No winner: MemRead=MemWrite=0; a, wd, Funct3 driven 0.
- last_gnt register is updated to the winner on every granted cycle. It holds otherwise.
- wait_cnt (8 bit):
  - clears when p1_gnt=1 or p1_req=0.
  - otherwise increments each cycle, saturating at MAX_WAIT.
  - p1_starved = (wait_cnt == MAX_WAIT).
- Load grant: rd is captured into pN_rdata at the end of the grant cycle, and pN_rvalid=1 the following cycle.
  - pN_rdata holds its value until the next load grant to that port.
- Store grant: the write commits inside the grant cycle, since memory writes on the falling clock edge. No rvalid is produced.
- The arbiter does not check or alter alignment or width. Funct3 is forwarded unchanged.

## Timing
- Grant latency: zero cycles. pN_gnt is asserted in the same cycle as pN_req when that port wins.
- Load-to-data latency: rvalid arrives one cycle after gnt.
- Throughput: one access per cycle total. Back-to-back grants to the same port are legal, and each produces its own rvalid.
- A requester deasserts req, or presents its next request, in the cycle after gnt. Fields must not change while req=1 and gnt=0.
- Reset (reset_n=0 at a rising edge) sets: pN_rvalid=0, pN_rdata=0, last_gnt=1 (port 0 wins the first round-robin tie), wait_cnt=0.
- While reset_n=0: pN_gnt=0, MemRead=MemWrite=0, a/wd/Funct3=0, p1_starved=0, independent of requests.
- Reset mid-operation: a load granted in the cycle before a reset edge produces no rvalid. A pending request must be re-presented and re-granted after reset.
- Worst-case port 1 wait: MAX_WAIT+1 cycles from req to gnt, under continuous port 0 requests with CPU_PRIORITY=1.

## Test plan
- Reset then a single p0 load, addr 0x010, funct3 010, memory word 0xDEADBEEF: p0_gnt the same cycle, p0_rvalid next cycle with p0_rdata=0xDEADBEEF; all outputs 0 during reset.
- p0 store 0x12345678 to addr 0x020 (funct3 010), then p1 load from 0x020 on the next cycle: p1_rdata=0x12345678, and p1_rvalid is one cycle after p1_gnt.
- CPU_PRIORITY=1, both ports requesting continuously, MAX_WAIT=8: p0 is granted 8 cycles, p1_starved rises, p1 is granted on cycle 9 and wait_cnt clears; the pattern repeats every 9 cycles.
- CPU_PRIORITY=0, both ports requesting continuously: grants alternate starting with p0 (p0, p1, p0, ...), and MemRead/MemWrite follow each winner's we.
- p0 load granted, reset_n driven low for one cycle at the next edge: no p0_rvalid, p0_rdata=0; after reset, a re-presented request is granted normally.
- Idle with no requests: MemRead=MemWrite=0, a=0, and no gnt or rvalid for 20 cycles.
